// File: rtl/bus_pkg.sv
// Shared bus definitions: packet layout, address field and broadcast constant.
// Used by the device FIFO, the agent, the arbiter wrapper and the scoreboard.
package bus_pkg;

    localparam int PCKG_SZ = 16;
    localparam int ADDR_W  = 8;
    localparam logic [ADDR_W-1:0] BCAST_ADDR = 8'hFF;

    typedef struct packed {
        logic [ADDR_W-1:0]         addr;
        logic [PCKG_SZ-ADDR_W-1:0] payload;
    } pkt_t;

    // Occupancy class of a FIFO as seen at a clock edge
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [ADDR_W-1:0] pkt_addr(input pkt_t p);
        return p.addr;
    endfunction

endpackage

// File: rtl/bus_dev_fifo_if.sv
// Device-FIFO bus bundle: push/pop strobes, head packet, occupancy and statistics.
// master = agent/arbiter side driving strobes; slave = the FIFO.
interface bus_dev_fifo_if #(
    parameter int pckg_sz = bus_pkg::PCKG_SZ,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
);

    logic                       push;
    logic [pckg_sz-1:0]         D_push;
    logic                       pop;
    logic [pckg_sz-1:0]         D_pop;
    logic                       pndng;
    logic                       full;
    logic [$clog2(depth):0]     count;
    logic [cnt_w-1:0]           drop_cnt;
    logic [cnt_w-1:0]           udf_cnt;
    logic                       clr_cnt;

    modport master (
        output push, D_push, pop, clr_cnt,
        input  D_pop, pndng, full, count, drop_cnt, udf_cnt
    );

    modport slave (
        input  push, D_push, pop, clr_cnt,
        output D_pop, pndng, full, count, drop_cnt, udf_cnt
    );

endinterface

// File: rtl/bus_fifo_mem.sv
// depth x width register array, one synchronous write port, one async read port.
// Write lands on the rising edge; read is combinational; no reset on contents.
module bus_fifo_mem #(
    parameter  int width = 16,
    parameter  int depth = 8,
    localparam int aw    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_dev_fifo.sv
// Per-device first-word-fall-through packet FIFO with saturating drop/underflow counters.
// Head visible one cycle after push into empty; no backpressure, pushes while full are dropped and counted.
module bus_dev_fifo
    import bus_pkg::*;
#(
    parameter int pckg_sz = PCKG_SZ,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
) (
    input  logic            clk,
    input  logic            reset,
    bus_dev_fifo_if.slave   bus
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [aw-1:0]      wr_ptr;
    logic [aw-1:0]      rd_ptr;
    logic [cw-1:0]      cnt_q;
    logic [cw-1:0]      cnt_d;
    logic [cnt_w-1:0]   drop_q;
    logic [cnt_w-1:0]   udf_q;
    logic [pckg_sz-1:0] rdata;

    occ_e occ;
    logic do_push;
    logic do_pop;
    logic drop;
    logic udf;

    always_comb begin
        occ = OCC_PART;
        if (cnt_q == '0) begin
            occ = OCC_EMPTY;
        end else if (cnt_q == cw'(depth)) begin
            occ = OCC_FULL;
        end
    end

    // When full, a simultaneous pop frees the slot the push lands in; when empty,
    // the push is taken but the pop still counts as an underflow (no bypass).
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        drop    = 1'b0;
        udf     = 1'b0;
        unique case (occ)
            OCC_EMPTY: begin
                do_push = bus.push;
                udf     = bus.pop;
            end
            OCC_FULL: begin
                do_pop  = bus.pop;
                do_push = bus.push & bus.pop;
                drop    = bus.push & ~bus.pop;
            end
            default: begin
                do_push = bus.push;
                do_pop  = bus.pop;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + cw'(1);
            2'b01:   cnt_d = cnt_q - cw'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Clear takes priority over a same-cycle increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
            udf_q  <= '0;
        end else if (bus.clr_cnt) begin
            drop_q <= '0;
            udf_q  <= '0;
        end else begin
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + cnt_w'(1);
            end
            if (udf && (udf_q != '1)) begin
                udf_q <= udf_q + cnt_w'(1);
            end
        end
    end

    bus_fifo_mem #(
        .width (pckg_sz),
        .depth (depth)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (bus.D_push),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.pndng    = (cnt_q != '0);
    assign bus.full     = (cnt_q == cw'(depth));
    assign bus.count    = cnt_q;
    assign bus.drop_cnt = drop_q;
    assign bus.udf_cnt  = udf_q;
    // Stale array contents stay hidden while nothing is pending
    assign bus.D_pop    = bus.pndng ? rdata : '0;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Self-checking bench for bus_dev_fifo against a queue-based reference model.
module tb_bus_dev_fifo;

    localparam int DEPTH   = 8;
    localparam int CNT_MAX = 255;

    logic clk;
    logic reset;

    bus_dev_fifo_if #(.pckg_sz(16), .depth(DEPTH), .cnt_w(8)) bus ();

    bus_dev_fifo #(.pckg_sz(16), .depth(DEPTH), .cnt_w(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] q[$];
    int          m_drop = 0;
    int          m_udf  = 0;
    logic [15:0] last_rd;
    int          max_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'(q.size()));
        chk({tag, "_pndng"}, 32'(bus.pndng), 32'(q.size() != 0));
        chk({tag, "_full"},  32'(bus.full),  32'(q.size() == DEPTH));
        chk({tag, "_drop"},  32'(bus.drop_cnt), 32'(m_drop));
        chk({tag, "_udf"},   32'(bus.udf_cnt),  32'(m_udf));
        if (q.size() != 0) chk({tag, "_head"}, 32'(bus.D_pop), 32'(q[0]));
    endtask

    // One bus cycle: drive at negedge, sample head before the edge, apply model, check after.
    task automatic cyc(input string tag, input logic p, input logic [15:0] d,
                       input logic pp, input logic c);
        bit was_empty;
        bit was_full;
        @(negedge clk);
        bus.push = p; bus.D_push = d; bus.pop = pp; bus.clr_cnt = c;
        #1;
        if (pp && q.size() != 0) begin
            chk({tag, "_rd"}, 32'(bus.D_pop), 32'(q[0]));
            last_rd = bus.D_pop;
        end
        @(posedge clk);
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        if (pp) begin
            if (was_empty) begin
                if (m_udf < CNT_MAX) m_udf++;
            end else begin
                void'(q.pop_front());
            end
        end
        if (p) begin
            if (was_full && !pp) begin
                if (m_drop < CNT_MAX) m_drop++;
            end else begin
                q.push_back(d);
            end
        end
        if (c) begin
            m_drop = 0;
            m_udf  = 0;
        end
        if (q.size() > max_cnt) max_cnt = q.size();
        #1;
        check_state(tag);
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_cnt = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_pndng", 32'(bus.pndng), 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_full",  32'(bus.full),  32'd0);
        chk("arst_dpop",  32'(bus.D_pop), 32'd0);
        q.delete();
        m_drop = 0;
        m_udf  = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.push = 1'b0; bus.D_push = '0; bus.pop = 1'b0; bus.clr_cnt = 1'b0;
        last_rd = '0;
        max_cnt = 0;
        #3;
        check_state("rst");
        chk("rst_dpop", 32'(bus.D_pop), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single push shows up at the head one cycle later
        cyc("p1", 1'b1, 16'hA501, 1'b0, 1'b0);
        cyc("idle", 1'b0, 16'h0, 1'b0, 1'b0);
        cyc("p1pop", 1'b0, 16'h0, 1'b1, 1'b0);

        // Fill, overflow by one, drain in order
        for (int i = 1; i <= 9; i++) cyc("fill", 1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  cyc("drain", 1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain_last", 32'(last_rd), 32'h0008);

        // Push+pop while full: accepted, no drop
        cyc("clr0", 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) cyc("fill2", 1'b1, 16'(16'h20 + i), 1'b0, 1'b0);
        cyc("fpp", 1'b1, 16'h0010, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  cyc("drain2", 1'b0, 16'h0, 1'b1, 1'b0);
        chk("fpp_last", 32'(last_rd), 32'h0010);

        // Alternating push/pop across pointer wrap
        max_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc("alt_push", 1'b1, 16'(i), 1'b0, 1'b0);
            cyc("alt_pop", 1'b0, 16'h0, 1'b1, 1'b0);
            chk("alt_val", 32'(last_rd), 32'(i));
        end
        chk("alt_max", 32'(max_cnt), 32'd1);

        // Underflow counting, clear beats increment, push+pop on empty
        for (int i = 0; i < 3; i++) cyc("udf", 1'b0, 16'h0, 1'b1, 1'b0);
        chk("udf3", 32'(bus.udf_cnt), 32'd3);
        cyc("udf_clr", 1'b0, 16'h0, 1'b1, 1'b1);
        chk("udf_clr0", 32'(bus.udf_cnt), 32'd0);
        cyc("epp", 1'b1, 16'h0077, 1'b1, 1'b0);
        chk("epp_udf", 32'(bus.udf_cnt), 32'd1);
        cyc("epp_pop", 1'b0, 16'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) cyc("pre_rst", 1'b1, 16'(16'h40 + i), 1'b0, 1'b0);
        async_reset();
        cyc("post_rst", 1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("post_rst_head", 32'(bus.D_pop), 32'hBEEF);

        // Randomised traffic: push-heavy, then pop-heavy
        for (int i = 0; i < 400; i++) begin
            int pp_thr;
            pp_thr = (i < 200) ? 35 : 65;
            cyc("rnd", ($urandom_range(0, 99) < 100 - pp_thr),
                16'($urandom()), ($urandom_range(0, 99) < pp_thr),
                ($urandom_range(0, 49) == 0));
        end

        // Drop counter saturation
        cyc("sat_clr", 1'b0, 16'h0, 1'b0, 1'b1);
        while (q.size() < DEPTH) cyc("sat_fill", 1'b1, 16'($urandom()), 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) cyc("sat", 1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("sat_drop", 32'(bus.drop_cnt), 32'd255);
        cyc("sat_clr2", 1'b1, 16'hDEAD, 1'b0, 1'b1);
        chk("sat_clr_drop", 32'(bus.drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
